wb_trace_fifo: RTL



---
 rtl/wb_trace_fifo_if.sv | 33 +++
 rtl/wb_trace_fifo.sv | 76 +++++++
 2 files changed

// File: rtl/wb_trace_fifo_if.sv
// Trace capture/drain signal bundle for wb_trace_fifo.
// The slave modport is the FIFO side and the master modport is the CPU/sink side.
interface wb_trace_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          trace_en;
  logic          clr;
  logic          wb_have_inst;
  logic [31:0]   wb_pc;
  logic          wb_ena;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_value;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [4:0]    out_reg;
  logic [31:0]   out_value;
  logic [AW:0]   count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  modport slave (
    input  trace_en, clr, wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    output out_valid, out_pc, out_reg, out_value, count, overflow, drop_cnt
  );

  modport master (
    output trace_en, clr, wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    input  out_valid, out_pc, out_reg, out_value, count, overflow, drop_cnt
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace capture buffer: show-ahead FIFO of retired register writes.
// It never stalls the CPU; events that find the FIFO full are dropped and counted.
module wb_trace_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_trace_fifo_if.slave  tif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [68:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf;
  logic [15:0]   drops;

  logic          cap;
  logic          pop;
  logic          push;
  logic          drop;
  logic          valid;
  logic [68:0]   head;

  always_comb begin
    valid = (cnt != '0);
    cap   = tif.trace_en & tif.wb_have_inst & tif.wb_ena & (tif.wb_reg != '0);
    pop   = valid & tif.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push  = cap & ((cnt != FULL_CNT) | pop);
    drop  = cap & ~push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else if (tif.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (drop) begin
        ovf <= 1'b1;
        if (drops != '1) drops <= drops + 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !tif.clr) mem[wr_ptr] <= {tif.wb_pc, tif.wb_reg, tif.wb_value};
  end

  always_comb begin
    head          = valid ? mem[rd_ptr] : '0;
    tif.out_valid = valid;
    tif.out_pc    = head[68:37];
    tif.out_reg   = head[36:32];
    tif.out_value = head[31:0];
    tif.count     = cnt;
    tif.overflow  = ovf;
    tif.drop_cnt  = drops;
  end
endmodule
